// File: rtl/ibex_trace_fifo.sv
// ibex_trace_fifo: first-word-fall-through buffer of RVFI retirement records.
// Define IBEX_TRACE_TIMESTAMP_EN to add a per-record cycle timestamp.
module ibex_trace_fifo #(
   parameter int unsigned Depth = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  rvfi_valid_i,
   input  logic [31:0]           rvfi_pc_rdata_i,
   input  logic [31:0]           rvfi_insn_i,
   input  logic [31:0]           rvfi_rd_wdata_i,
   input  logic [31:0]           rvfi_mem_addr_i,
   input  logic [4:0]            rvfi_rd_addr_i,
   input  logic                  rvfi_trap_i,
   input  logic                  clear_i,
   output logic                  trace_valid_o,
   input  logic                  trace_ready_i,
   output logic [31:0]           trace_pc_o,
   output logic [31:0]           trace_insn_o,
   output logic [31:0]           trace_rd_wdata_o,
   output logic [31:0]           trace_mem_addr_o,
   output logic [4:0]            trace_rd_addr_o,
   output logic                  trace_trap_o,
   output logic                  trace_gap_o,
`ifdef IBEX_TRACE_TIMESTAMP_EN
   output logic [31:0]           trace_time_o,
`endif
   output logic [$clog2(Depth):0] level_o,
   output logic                  overflow_o,
   output logic [15:0]           drop_cnt_o
);

   localparam int unsigned AW = $clog2(Depth);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] Full = LW'(Depth);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [31:0] rd_wdata;
      logic [31:0] mem_addr;
      logic [4:0]  rd_addr;
      logic        trap;
      logic        gap;
`ifdef IBEX_TRACE_TIMESTAMP_EN
      logic [31:0] tstamp;
`endif
   } rec_t;

   rec_t          mem [Depth];
   rec_t          wr_rec;
   rec_t          head;
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [LW-1:0] count;
   logic          gap_pend;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;

`ifdef IBEX_TRACE_TIMESTAMP_EN
   logic [31:0] tstamp;

   // Free-running; clear_i deliberately leaves it alone.
   always_ff @(posedge clk_i) begin
      if (rst_i) tstamp <= '0;
      else       tstamp <= tstamp + 32'd1;
   end
`endif

   assign full          = (count == Full);
   assign trace_valid_o = (count != '0);
   assign pop           = trace_valid_o & trace_ready_i;
   assign push          = rvfi_valid_i & (~full | pop);
   assign drop          = rvfi_valid_i & full & ~pop;

   always_comb begin
      wr_rec          = '0;
      wr_rec.pc       = rvfi_pc_rdata_i;
      wr_rec.insn     = rvfi_insn_i;
      wr_rec.rd_wdata = rvfi_rd_wdata_i;
      wr_rec.mem_addr = rvfi_mem_addr_i;
      wr_rec.rd_addr  = rvfi_rd_addr_i;
      wr_rec.trap     = rvfi_trap_i;
      wr_rec.gap      = gap_pend;
`ifdef IBEX_TRACE_TIMESTAMP_EN
      wr_rec.tstamp   = tstamp;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (push && !rst_i && !clear_i) mem[wptr] <= wr_rec;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
         gap_pend   <= 1'b0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
         if (drop) begin
            overflow_o <= 1'b1;
            gap_pend   <= 1'b1;
            if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
         end else if (push) begin
            gap_pend <= 1'b0;
         end
      end
   end

   // Zero the head view whenever the buffer is empty.
   assign head = trace_valid_o ? mem[rptr] : '0;

   assign trace_pc_o       = head.pc;
   assign trace_insn_o     = head.insn;
   assign trace_rd_wdata_o = head.rd_wdata;
   assign trace_mem_addr_o = head.mem_addr;
   assign trace_rd_addr_o  = head.rd_addr;
   assign trace_trap_o     = head.trap;
   assign trace_gap_o      = head.gap;
`ifdef IBEX_TRACE_TIMESTAMP_EN
   assign trace_time_o     = head.tstamp;
`endif
   assign level_o          = count;

endmodule

// File: tb/tb_ibex_trace_fifo.sv
// tb_ibex_trace_fifo: random and directed stimulus against a queue model.
// Optional timestamp checks follow IBEX_TRACE_TIMESTAMP_EN.
module tb_ibex_trace_fifo;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        rvfi_valid_i = 1'b0;
   logic [31:0] rvfi_pc_rdata_i = '0;
   logic [31:0] rvfi_insn_i = '0;
   logic [31:0] rvfi_rd_wdata_i = '0;
   logic [31:0] rvfi_mem_addr_i = '0;
   logic [4:0]  rvfi_rd_addr_i = '0;
   logic        rvfi_trap_i = 1'b0;
   logic        clear_i = 1'b0;
   logic        trace_valid_o;
   logic        trace_ready_i = 1'b0;
   logic [31:0] trace_pc_o;
   logic [31:0] trace_insn_o;
   logic [31:0] trace_rd_wdata_o;
   logic [31:0] trace_mem_addr_o;
   logic [4:0]  trace_rd_addr_o;
   logic        trace_trap_o;
   logic        trace_gap_o;
`ifdef IBEX_TRACE_TIMESTAMP_EN
   logic [31:0] trace_time_o;
`endif
   logic [3:0]  level_o;
   logic        overflow_o;
   logic [15:0] drop_cnt_o;

   ibex_trace_fifo #(.Depth(DEPTH)) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .rvfi_valid_i(rvfi_valid_i),
      .rvfi_pc_rdata_i(rvfi_pc_rdata_i),
      .rvfi_insn_i(rvfi_insn_i),
      .rvfi_rd_wdata_i(rvfi_rd_wdata_i),
      .rvfi_mem_addr_i(rvfi_mem_addr_i),
      .rvfi_rd_addr_i(rvfi_rd_addr_i),
      .rvfi_trap_i(rvfi_trap_i),
      .clear_i(clear_i),
      .trace_valid_o(trace_valid_o),
      .trace_ready_i(trace_ready_i),
      .trace_pc_o(trace_pc_o),
      .trace_insn_o(trace_insn_o),
      .trace_rd_wdata_o(trace_rd_wdata_o),
      .trace_mem_addr_o(trace_mem_addr_o),
      .trace_rd_addr_o(trace_rd_addr_o),
      .trace_trap_o(trace_trap_o),
      .trace_gap_o(trace_gap_o),
`ifdef IBEX_TRACE_TIMESTAMP_EN
      .trace_time_o(trace_time_o),
`endif
      .level_o(level_o),
      .overflow_o(overflow_o),
      .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [31:0] rdw;
      logic [31:0] ma;
      logic [4:0]  rd;
      logic        trap;
      logic        gap;
      logic [31:0] ts;
   } mrec_t;

   mrec_t       q[$];
   int          m_drops;
   logic        m_ovf;
   logic        m_gap;
   logic [31:0] m_ts;
   bit          armed = 0;
   int          n_pass = 0;
   int          n_chk = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic check_all();
      mrec_t e;
      e = '{default: '0};
      if (q.size() != 0) e = q[0];
      chk("valid", 32'(trace_valid_o), 32'(q.size() != 0));
      chk("pc", trace_pc_o, e.pc);
      chk("insn", trace_insn_o, e.insn);
      chk("rdw", trace_rd_wdata_o, e.rdw);
      chk("maddr", trace_mem_addr_o, e.ma);
      chk("rd", 32'(trace_rd_addr_o), 32'(e.rd));
      chk("trap", 32'(trace_trap_o), 32'(e.trap));
      chk("gap", 32'(trace_gap_o), 32'(e.gap));
      chk("level", 32'(level_o), 32'(q.size()));
      chk("ovf", 32'(overflow_o), 32'(m_ovf));
      chk("drops", 32'(drop_cnt_o), 32'(m_drops));
`ifdef IBEX_TRACE_TIMESTAMP_EN
      chk("time", trace_time_o, e.ts);
`endif
   endtask

   // One cycle: drive at negedge, check, then advance the model at posedge.
   task automatic step(input logic v, input logic rdy, input logic clr,
                       input logic rst, input logic [31:0] pc,
                       input logic [31:0] insn);
      mrec_t r;
      bit    pop;
      bit    full;
      @(negedge clk);
      rvfi_valid_i    = v;
      rvfi_pc_rdata_i = pc;
      rvfi_insn_i     = insn;
      rvfi_rd_wdata_i = $urandom();
      rvfi_mem_addr_i = $urandom();
      rvfi_rd_addr_i  = 5'($urandom());
      rvfi_trap_i     = 1'($urandom());
      trace_ready_i   = rdy;
      clear_i         = clr;
      rst_i           = rst;
      if (armed) check_all();
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_drops = 0;
         m_ovf   = 1'b0;
         m_gap   = 1'b0;
         m_ts    = '0;
         armed   = 1;
      end else begin
         if (clr) begin
            q.delete();
            m_drops = 0;
            m_ovf   = 1'b0;
            m_gap   = 1'b0;
         end else begin
            pop  = (q.size() != 0) && rdy;
            full = (q.size() == DEPTH);
            if (pop) void'(q.pop_front());
            if (v) begin
               if (!full || pop) begin
                  r.pc   = rvfi_pc_rdata_i;
                  r.insn = rvfi_insn_i;
                  r.rdw  = rvfi_rd_wdata_i;
                  r.ma   = rvfi_mem_addr_i;
                  r.rd   = rvfi_rd_addr_i;
                  r.trap = rvfi_trap_i;
                  r.gap  = m_gap;
                  r.ts   = m_ts;
                  q.push_back(r);
                  m_gap  = 1'b0;
               end else begin
                  if (m_drops < 65535) m_drops++;
                  m_ovf = 1'b1;
                  m_gap = 1'b1;
               end
            end
         end
         m_ts = m_ts + 32'd1;
      end
   endtask

   task automatic rstep(input logic v, input logic rdy, input logic clr);
      step(v, rdy, clr, 1'b0, $urandom(), $urandom());
   endtask

   initial begin
      // Reset state
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h1, 32'h1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      #1;
      chk("rst_valid", 32'(trace_valid_o), 32'd0);
      chk("rst_level", 32'(level_o), 32'd0);

      // Single push then pop
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h00000013);
      #1;
      chk("one_valid", 32'(trace_valid_o), 32'd1);
      chk("one_pc", trace_pc_o, 32'h100);
      chk("one_insn", trace_insn_o, 32'h00000013);
      rstep(1'b0, 1'b1, 1'b0);
      #1;
      chk("one_level", 32'(level_o), 32'd0);

      // Overflow: 10 pushes with downstream stalled
      for (int i = 0; i < 10; i++) rstep(1'b1, 1'b0, 1'b0);
      #1;
      chk("ovf_level", 32'(level_o), 32'd8);
      chk("ovf_drops", 32'(drop_cnt_o), 32'd2);
      chk("ovf_flag", 32'(overflow_o), 32'd1);
      for (int i = 0; i < 8; i++) rstep(1'b0, 1'b1, 1'b0);
      rstep(1'b1, 1'b0, 1'b0);
      #1;
      chk("gap_set", 32'(trace_gap_o), 32'd1);
      rstep(1'b1, 1'b1, 1'b0);
      #1;
      chk("gap_next", 32'(trace_gap_o), 32'd0);

      // Full with simultaneous push and pop across pointer wrap
      for (int i = 0; i < 8; i++) rstep(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) rstep(1'b1, 1'b1, 1'b0);
      #1;
      chk("full_pp_level", 32'(level_o), 32'd8);
      for (int i = 0; i < 10; i++) rstep(1'b0, 1'b1, 1'b0);

      // Random traffic
      for (int i = 0; i < 3000; i++)
         rstep(1'($urandom()), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 60) == 0));

      // Saturating drop counter, then clear with concurrent push
      for (int i = 0; i < 70010; i++) rstep(1'b1, 1'b0, 1'b0);
      #1;
      chk("sat_drops", 32'(drop_cnt_o), 32'h0000FFFF);
      rstep(1'b1, 1'b1, 1'b1);
      #1;
      chk("clr_level", 32'(level_o), 32'd0);
      chk("clr_drops", 32'(drop_cnt_o), 32'd0);
      chk("clr_ovf", 32'(overflow_o), 32'd0);
      chk("clr_valid", 32'(trace_valid_o), 32'd0);

      // Reset with 5 records buffered
      for (int i = 0; i < 5; i++) rstep(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'h55, 32'h66);
      #1;
      chk("mrst_valid", 32'(trace_valid_o), 32'd0);
      chk("mrst_pc", trace_pc_o, 32'd0);
      chk("mrst_level", 32'(level_o), 32'd0);
`ifdef IBEX_TRACE_TIMESTAMP_EN
      for (int i = 0; i < 3; i++) rstep(1'b0, 1'b0, 1'b0);
      rstep(1'b1, 1'b0, 1'b0);
      #1;
      chk("ts_three", trace_time_o, 32'd3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
`endif

      // Push in the first cycle after reset
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h00100093);
      #1;
      chk("post_rst_valid", 32'(trace_valid_o), 32'd1);
      chk("post_rst_pc", trace_pc_o, 32'h200);
      for (int i = 0; i < 200; i++)
         rstep(1'($urandom()), 1'($urandom()), 1'b0);
      rstep(1'b0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
